// File: rtl/axi_wr_burst_engine_pkg.sv
// Shared types and constants for the AXI4 write burst engine.
package axi_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] AXSIZE_4B   = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BOUNDARY_4K = 4096;

  // Wide enough to hold a part length of 64 beats.
  localparam int LEN_W = 7;

endpackage

// File: rtl/axi_wr_burst_engine_splitter.sv
// Splits a (clamped) command into at most two INCR bursts so that neither
// burst crosses a 4 KB address boundary.
module burst_splitter
  import axi_wr_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic [LEN_W-1:0]  part1_len,
  output logic [LEN_W-1:0]  part2_len,
  output logic [ADDR_W-1:0] part2_addr,
  output logic              has_part2
);

  logic [10:0] beats_to_boundary;

  // Range is 1..1024 beats, so 11 bits are enough.
  assign beats_to_boundary = 11'((13'(BOUNDARY_4K) - {1'b0, addr[11:0]}) >> 2);
  assign has_part2         = {4'b0000, len} > beats_to_boundary;
  assign part1_len         = has_part2 ? beats_to_boundary[LEN_W-1:0] : len;
  assign part2_len         = len - part1_len;
  assign part2_addr        = {addr[ADDR_W-1:12] + (ADDR_W-12)'(1), 12'h000};

endmodule

// File: rtl/axi_wr_burst_engine.sv
// Turns {len, addr} commands plus a data stream into AXI4 INCR write bursts,
// one burst in flight at a time, splitting at 4 KB boundaries.
module axi_wr_burst_engine
  import axi_wr_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W+7:0]          cmd_in,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [DATA_W+DATA_W/8-1:0] wd_in,
  input  logic                       wd_valid,
  output logic                       wd_ready,
  output logic [ADDR_W-1:0]          m_awaddr,
  output logic [7:0]                 m_awlen,
  output logic [2:0]                 m_awsize,
  output logic [1:0]                 m_awburst,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  output logic                       m_wlast,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  input  logic [1:0]                 m_bresp,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  output logic                       busy,
  output logic                       err_resp,
  output logic                       err_len
);

  state_t state, state_next;

  logic [7:0]        cmd_len;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_len_big;
  logic [LEN_W-1:0]  cmd_len_c;

  logic [LEN_W-1:0]  sp_part1_len;
  logic [LEN_W-1:0]  sp_part2_len;
  logic [ADDR_W-1:0] sp_part2_addr;
  logic              sp_has_part2;

  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  cur_len_m1;
  logic              part2_pend;
  logic [ADDR_W-1:0] part2_addr_q;
  logic [LEN_W-1:0]  part2_len_q;
  logic [LEN_W-1:0]  beat_cnt;

  logic cmd_take;
  logic w_fire;
  logic last_beat;

  assign cmd_len     = cmd_in[ADDR_W+7:ADDR_W];
  assign cmd_addr    = cmd_in[ADDR_W-1:0];
  assign cmd_len_big = cmd_len > 8'(MAX_LEN);
  assign cmd_len_c   = cmd_len_big ? LEN_W'(MAX_LEN) : cmd_len[LEN_W-1:0];

  burst_splitter #(.ADDR_W(ADDR_W)) u_splitter (
    .addr       (cmd_addr),
    .len        (cmd_len_c),
    .part1_len  (sp_part1_len),
    .part2_len  (sp_part2_len),
    .part2_addr (sp_part2_addr),
    .has_part2  (sp_has_part2)
  );

  // A zero-length command is popped but never leaves IDLE.
  assign cmd_take  = (state == IDLE) && cmd_valid && (cmd_len != 8'd0);
  assign w_fire    = (state == DATA) && wd_valid && m_wready;
  assign last_beat = (beat_cnt == cur_len_m1);

  assign m_awaddr  = cur_addr;
  assign m_awlen   = {1'b0, cur_len_m1};
  assign m_awsize  = AXSIZE_4B;
  assign m_awburst = BURST_INCR;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    wd_ready   = 1'b0;
    m_wlast    = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_bready   = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = cmd_valid;
        if (cmd_take) state_next = ADDR;
      end
      ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) state_next = DATA;
      end
      DATA: begin
        m_wvalid = wd_valid;
        wd_ready = m_wready;
        m_wlast  = last_beat;
        m_wdata  = wd_in[DATA_W-1:0];
        m_wstrb  = wd_in[DATA_W+DATA_W/8-1:DATA_W];
        if (w_fire && last_beat) state_next = RESP;
      end
      RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) state_next = part2_pend ? ADDR : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr     <= '0;
      cur_len_m1   <= '0;
      part2_pend   <= 1'b0;
      part2_addr_q <= '0;
      part2_len_q  <= '0;
      beat_cnt     <= '0;
      err_resp     <= 1'b0;
      err_len      <= 1'b0;
    end else begin
      if (cmd_take) begin
        cur_addr     <= {cmd_addr[ADDR_W-1:2], 2'b00};
        cur_len_m1   <= sp_part1_len - LEN_W'(1);
        part2_pend   <= sp_has_part2;
        part2_addr_q <= sp_part2_addr;
        part2_len_q  <= sp_part2_len;
        if (cmd_len_big) err_len <= 1'b1;
      end

      if (state == ADDR && m_awready) begin
        beat_cnt <= '0;
      end else if (w_fire) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end

      // Second half of a split burst is issued only after the first B.
      if (state == RESP && m_bvalid) begin
        if (m_bresp != RESP_OKAY) err_resp <= 1'b1;
        if (part2_pend) begin
          cur_addr   <= part2_addr_q;
          cur_len_m1 <= part2_len_q - LEN_W'(1);
          part2_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_engine.sv
// Directed bench for axi_wr_burst_engine: FIFO model on the input side,
// simple AXI slave on the output side, one task per scenario.
module tb_axi_wr_burst_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] cmd_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [35:0] wd_in;
  logic        wd_valid;
  logic        wd_ready;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic        busy;
  logic        err_resp;
  logic        err_len;

  always #5 clk = ~clk;

  axi_wr_burst_engine dut (
    .clk(clk), .rst(rst),
    .cmd_in(cmd_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .wd_in(wd_in), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .err_resp(err_resp), .err_len(err_len)
  );

  // Data FIFO model
  logic [35:0] fifo [0:1023];
  logic [9:0]  wr_ptr = '0;
  logic [9:0]  rd_ptr = '0;
  logic        gap = 1'b0;
  assign wd_valid = (wr_ptr != rd_ptr) && !gap;
  assign wd_in    = fifo[rd_ptr];

  // Observation logs
  logic [35:0] w_log      [0:127];
  logic        w_last_log [0:127];
  logic [31:0] aw_addr_log[0:7];
  logic [7:0]  aw_len_log [0:7];
  int          aw_cyc     [0:7];
  int          b_cyc      [0:7];
  int w_n, aw_n, b_n, pop_n, pop_cyc, first_awv_cyc, cyc, aw_unstable;
  logic busy_after_b, b_prev, aw_hold, rand_mode;
  logic [31:0] hold_addr;
  logic [7:0]  hold_len;
  logic [1:0]  bresp_first;
  int gap_at, gap_cnt;
  int passed = 0;
  int total = 0;

  task automatic push(input logic [35:0] v);
    fifo[wr_ptr] = v;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  task automatic clear_logs();
    w_n = 0; aw_n = 0; b_n = 0; pop_n = 0; pop_cyc = -1; first_awv_cyc = -1;
    aw_unstable = 0; busy_after_b = 1'bx; b_prev = 1'b0; aw_hold = 1'b0;
    gap_at = -1; gap_cnt = 0; gap = 1'b0;
    m_bresp = bresp_first;
  endtask

  // One clock: observe at negedge, apply responses just after posedge.
  task automatic step();
    logic w_fire, aw_fire, b_fire, c_fire;
    @(negedge clk);
    cyc++;
    w_fire  = m_wvalid && m_wready;
    aw_fire = m_awvalid && m_awready;
    b_fire  = m_bvalid && m_bready;
    c_fire  = cmd_valid && cmd_ready;
    if (b_prev) busy_after_b = busy;
    b_prev = b_fire;
    if (aw_hold && (m_awaddr !== hold_addr || m_awlen !== hold_len || !m_awvalid))
      aw_unstable++;
    aw_hold = m_awvalid && !m_awready;
    hold_addr = m_awaddr;
    hold_len = m_awlen;
    if (m_awvalid && first_awv_cyc < 0) first_awv_cyc = cyc;
    if (c_fire) begin pop_n++; pop_cyc = cyc; end
    if (w_fire) begin
      if (w_n < 128) begin w_log[w_n] = {m_wstrb, m_wdata}; w_last_log[w_n] = m_wlast; end
      w_n++;
    end
    if (aw_fire) begin
      if (aw_n < 8) begin aw_addr_log[aw_n] = m_awaddr; aw_len_log[aw_n] = m_awlen; aw_cyc[aw_n] = cyc; end
      aw_n++;
    end
    if (b_fire) begin
      if (b_n < 8) b_cyc[b_n] = cyc;
      b_n++;
    end
    @(posedge clk);
    #1;
    if (w_fire) rd_ptr = rd_ptr + 10'd1;
    if (c_fire) cmd_valid = 1'b0;
    if (gap_cnt > 0) gap_cnt--;
    else if (gap_at >= 0 && w_n >= gap_at) begin gap_cnt = 3; gap_at = -1; end
    gap = (gap_cnt > 0);
    m_bresp = (b_n == 0) ? bresp_first : 2'b00;
    if (rand_mode) begin
      m_awready = ($urandom_range(0, 1) == 1);
      m_wready  = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic run_cmd(input logic [7:0] len, input logic [31:0] addr, output logic done);
    cmd_in = {len, addr};
    cmd_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!cmd_valid && !busy) begin done = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_in = '0;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    bresp_first = 2'b00; rand_mode = 1'b0; cyc = 0;
    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({m_awvalid, m_wvalid, m_bready, cmd_ready, wd_ready, m_wlast, busy} !== 7'b0)
      $display("FAIL reset_ctrl got %b want 0000000", {m_awvalid, m_wvalid, m_bready, cmd_ready, wd_ready, m_wlast, busy}); else passed++;
    total++; if ({m_awaddr, m_awlen, m_wdata, m_wstrb} !== 76'b0)
      $display("FAIL reset_data got %h want 0", {m_awaddr, m_awlen, m_wdata, m_wstrb}); else passed++;
    total++; if ({err_resp, err_len} !== 2'b00)
      $display("FAIL reset_err got %b want 00", {err_resp, err_len}); else passed++;
    total++; if ({m_awsize, m_awburst} !== 5'b010_01)
      $display("FAIL reset_const got %b want 01001", {m_awsize, m_awburst}); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_main();
    logic done; int bad; int lasts;
    clear_logs();
    for (int i = 0; i < 64; i++) push({4'hF, 32'(i)});
    run_cmd(8'd64, 32'h0000_0000, done);
    step();
    bad = 0; lasts = 0;
    for (int k = 0; k < 64; k++) begin
      if (w_log[k] !== {4'hF, 32'(k)}) bad++;
      if (w_last_log[k]) lasts++;
    end
    total++; if (done !== 1'b1) $display("FAIL main_done got %b want 1", done); else passed++;
    total++; if (aw_n !== 1) $display("FAIL main_aw_count got %0d want 1", aw_n); else passed++;
    total++; if (aw_addr_log[0] !== 32'h0 || aw_len_log[0] !== 8'd63)
      $display("FAIL main_aw got %h/%0d want 0/63", aw_addr_log[0], aw_len_log[0]); else passed++;
    total++; if (w_n !== 64) $display("FAIL main_w_count got %0d want 64", w_n); else passed++;
    total++; if (bad !== 0) $display("FAIL main_data got %0d bad beats want 0", bad); else passed++;
    total++; if (lasts !== 1 || w_last_log[63] !== 1'b1)
      $display("FAIL main_wlast got count %0d last %b want 1/1", lasts, w_last_log[63]); else passed++;
    total++; if (pop_n !== 1) $display("FAIL main_pops got %0d want 1", pop_n); else passed++;
    total++; if (first_awv_cyc - pop_cyc !== 1)
      $display("FAIL main_aw_latency got %0d want 1", first_awv_cyc - pop_cyc); else passed++;
    total++; if (busy_after_b !== 1'b0) $display("FAIL main_busy_after_b got %b want 0", busy_after_b); else passed++;
  endtask

  task automatic test_small();
    logic done; int bad; int lasts;
    clear_logs();
    for (int i = 0; i < 5; i++) push({4'h3, 32'h5000_0000 + 32'(i)});
    run_cmd(8'd5, 32'h0000_1900, done);
    bad = 0; lasts = 0;
    for (int k = 0; k < 5; k++) begin
      if (w_log[k] !== {4'h3, 32'h5000_0000 + 32'(k)}) bad++;
      if (w_last_log[k]) lasts++;
    end
    total++; if (done !== 1'b1 || aw_n !== 1) $display("FAIL small_aw_count got %0d done %b want 1", aw_n, done); else passed++;
    total++; if (aw_addr_log[0] !== 32'h1900 || aw_len_log[0] !== 8'd4)
      $display("FAIL small_aw got %h/%0d want 1900/4", aw_addr_log[0], aw_len_log[0]); else passed++;
    total++; if (w_n !== 5 || bad !== 0) $display("FAIL small_data got %0d beats %0d bad want 5/0", w_n, bad); else passed++;
    total++; if (lasts !== 1 || w_last_log[4] !== 1'b1)
      $display("FAIL small_wlast got count %0d last %b want 1/1", lasts, w_last_log[4]); else passed++;
  endtask

  task automatic test_split();
    logic done; int bad; int lasts;
    clear_logs();
    for (int i = 0; i < 32; i++) push({4'hA, 32'hC000_0000 + 32'(i)});
    run_cmd(8'd32, 32'h0000_0FC0, done);
    bad = 0; lasts = 0;
    for (int k = 0; k < 32; k++) begin
      if (w_log[k] !== {4'hA, 32'hC000_0000 + 32'(k)}) bad++;
      if (w_last_log[k]) lasts++;
    end
    total++; if (done !== 1'b1 || aw_n !== 2) $display("FAIL split_aw_count got %0d done %b want 2", aw_n, done); else passed++;
    total++; if (aw_addr_log[0] !== 32'h0FC0 || aw_len_log[0] !== 8'd15)
      $display("FAIL split_aw0 got %h/%0d want fc0/15", aw_addr_log[0], aw_len_log[0]); else passed++;
    total++; if (aw_addr_log[1] !== 32'h1000 || aw_len_log[1] !== 8'd15)
      $display("FAIL split_aw1 got %h/%0d want 1000/15", aw_addr_log[1], aw_len_log[1]); else passed++;
    total++; if (w_n !== 32 || bad !== 0) $display("FAIL split_data got %0d beats %0d bad want 32/0", w_n, bad); else passed++;
    total++; if (lasts !== 2 || w_last_log[15] !== 1'b1 || w_last_log[31] !== 1'b1)
      $display("FAIL split_wlast got count %0d at15 %b at31 %b want 2/1/1", lasts, w_last_log[15], w_last_log[31]); else passed++;
    total++; if (b_n !== 2 || b_cyc[0] >= aw_cyc[1])
      $display("FAIL split_b_order got b_n %0d b0 %0d aw1 %0d want 2 and b0<aw1", b_n, b_cyc[0], aw_cyc[1]); else passed++;
  endtask

  task automatic test_stall();
    logic done; int bad; int lasts;
    clear_logs();
    for (int i = 0; i < 64; i++) push({4'(i), 32'h7700_0000 + 32'(i)});
    rand_mode = 1'b1; gap_at = 20;
    m_awready = 1'b0;
    run_cmd(8'd64, 32'h0000_0100, done);
    rand_mode = 1'b0; m_awready = 1'b1; m_wready = 1'b1;
    bad = 0; lasts = 0;
    for (int k = 0; k < 64; k++) begin
      if (w_log[k] !== {4'(k), 32'h7700_0000 + 32'(k)}) bad++;
      if (w_last_log[k]) lasts++;
    end
    total++; if (done !== 1'b1) $display("FAIL stall_done got %b want 1", done); else passed++;
    total++; if (w_n !== 64 || bad !== 0) $display("FAIL stall_data got %0d beats %0d bad want 64/0", w_n, bad); else passed++;
    total++; if (aw_unstable !== 0) $display("FAIL stall_aw_stable got %0d changes want 0", aw_unstable); else passed++;
    total++; if (aw_n !== 1 || aw_addr_log[0] !== 32'h100 || aw_len_log[0] !== 8'd63)
      $display("FAIL stall_aw got %0d %h/%0d want 1 100/63", aw_n, aw_addr_log[0], aw_len_log[0]); else passed++;
    total++; if (lasts !== 1 || w_last_log[63] !== 1'b1)
      $display("FAIL stall_wlast got count %0d last %b want 1/1", lasts, w_last_log[63]); else passed++;
  endtask

  task automatic test_bresp();
    logic done; int bad;
    total++; if (err_resp !== 1'b0) $display("FAIL bresp_pre got %b want 0", err_resp); else passed++;
    bresp_first = 2'b10;
    clear_logs();
    for (int i = 0; i < 8; i++) push({4'h5, 32'hB000_0000 + 32'(i)});
    run_cmd(8'd8, 32'h0000_0FF8, done);
    bresp_first = 2'b00;
    bad = 0;
    for (int k = 0; k < 8; k++) if (w_log[k] !== {4'h5, 32'hB000_0000 + 32'(k)}) bad++;
    total++; if (err_resp !== 1'b1) $display("FAIL bresp_err got %b want 1", err_resp); else passed++;
    total++; if (done !== 1'b1 || aw_n !== 2 || b_n !== 2)
      $display("FAIL bresp_bursts got aw %0d b %0d want 2/2", aw_n, b_n); else passed++;
    total++; if (aw_len_log[0] !== 8'd1 || aw_addr_log[1] !== 32'h1000 || aw_len_log[1] !== 8'd5)
      $display("FAIL bresp_split got %0d %h/%0d want 1 1000/5", aw_len_log[0], aw_addr_log[1], aw_len_log[1]); else passed++;
    total++; if (w_n !== 8 || bad !== 0) $display("FAIL bresp_data got %0d beats %0d bad want 8/0", w_n, bad); else passed++;
  endtask

  task automatic test_len0();
    logic done;
    clear_logs();
    run_cmd(8'd0, 32'h0000_2000, done);
    repeat (4) step();
    total++; if (done !== 1'b1 || pop_n !== 1) $display("FAIL len0_pop got %0d done %b want 1", pop_n, done); else passed++;
    total++; if (aw_n !== 0 || busy !== 1'b0) $display("FAIL len0_no_aw got aw %0d busy %b want 0/0", aw_n, busy); else passed++;
    total++; if (err_len !== 1'b0) $display("FAIL len0_err got %b want 0", err_len); else passed++;
  endtask

  task automatic test_len70();
    logic done;
    clear_logs();
    for (int i = 0; i < 64; i++) push({4'hF, 32'hD000_0000 + 32'(i)});
    run_cmd(8'd70, 32'h0000_3000, done);
    total++; if (err_len !== 1'b1) $display("FAIL len70_err got %b want 1", err_len); else passed++;
    total++; if (done !== 1'b1 || aw_n !== 1 || aw_len_log[0] !== 8'd63 || aw_addr_log[0] !== 32'h3000)
      $display("FAIL len70_aw got %0d %h/%0d want 1 3000/63", aw_n, aw_addr_log[0], aw_len_log[0]); else passed++;
    total++; if (w_n !== 64 || w_log[63] !== {4'hF, 32'hD000_003F})
      $display("FAIL len70_data got %0d beats last %h want 64 fd000003f", w_n, w_log[63]); else passed++;
    total++; if (err_resp !== 1'b1) $display("FAIL len70_err_resp_sticky got %b want 1", err_resp); else passed++;
  endtask

  task automatic test_reset_mid();
    logic hit;
    clear_logs();
    for (int i = 0; i < 64; i++) push({4'hF, 32'hE000_0000 + 32'(i)});
    cmd_in = {8'd64, 32'h0000_4000};
    cmd_valid = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 500; n++) begin
      step();
      if (w_n >= 20) begin hit = 1'b1; break; end
    end
    total++; if (hit !== 1'b1) $display("FAIL rstmid_reach got %0d beats want 20", w_n); else passed++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if ({m_awvalid, m_wvalid, m_bready, busy} !== 4'b0000)
      $display("FAIL rstmid_valids got %b want 0000", {m_awvalid, m_wvalid, m_bready, busy}); else passed++;
    total++; if ({err_resp, err_len} !== 2'b00)
      $display("FAIL rstmid_sticky_clear got %b want 00", {err_resp, err_len}); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_main();
    test_small();
    test_split();
    test_stall();
    test_bresp();
    test_len0();
    test_len70();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
